// File: rtl/gshare_predictor_x_if.sv
// Fetch/execute-side bundle for gshare_predictor_x.
// Handshake: a request transfers on a clock edge where pred_valid && pred_ready;
// its response appears with resp_valid high for exactly one cycle on the next
// cycle and cannot be stalled. upd_valid is a one-cycle strobe with no ready:
// the predictor takes one resolved branch per cycle and ignores strobes while
// the table is being cleared. dbg_state mirrors the predictor's FSM
// (0 = clearing the table, 1 = running).
interface gshare_predictor_x_if #(
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_LEN    = 10
);
    logic                   pred_valid;
    logic [31:0]            pred_pc;
    logic                   pred_ready;
    logic                   resp_valid;
    logic                   resp_taken;
    logic [INDEX_WIDTH-1:0] resp_index;
    logic [HIST_LEN-1:0]    resp_ghr;
    logic                   upd_valid;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic                   upd_taken;
    logic                   upd_mispredict;
    logic [HIST_LEN-1:0]    upd_ghr;
    logic                   dbg_state;

    // Fetch/execute side.
    modport master (
        output pred_valid, pred_pc,
        input  pred_ready,
        input  resp_valid, resp_taken, resp_index, resp_ghr,
        output upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
        input  dbg_state
    );

    // Predictor side.
    modport slave (
        input  pred_valid, pred_pc,
        output pred_ready,
        output resp_valid, resp_taken, resp_index, resp_ghr,
        input  upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
        output dbg_state
    );
endinterface

// File: rtl/gshare_predictor_x.sv
// gshare_predictor_x: parametrised bimodal/gshare direction predictor.
// - PHT of 2^INDEX_WIDTH saturating counters, cleared to weak-not-taken by a
//   power-up FSM (one entry per cycle) before requests are accepted.
// - Predict port: synchronous read, response one cycle after acceptance.
// - Update port: two-stage read-modify-write, one update per cycle, with
//   forwarding of the previous write when the same entry is hit back to back.
// - Speculative global history with restore from the checkpoint on mispredict.
// Optional build macro PRED_STATS_EN adds stat_updates / stat_mispredicts.
module gshare_predictor_x #(
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_LEN    = 10,
    parameter int CTR_WIDTH   = 2,
    parameter int MODE        = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    gshare_predictor_x_if.slave  bp
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]          stat_updates,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift one outcome into the young end of a history vector.
    function automatic logic [HIST_LEN-1:0] hist_shift(input logic [HIST_LEN-1:0] h,
                                                       input logic b);
        logic [HIST_LEN-1:0] r;
        r    = '0;
        r[0] = b;
        for (int i = 1; i < HIST_LEN; i++) begin
            r[i] = h[i-1];
        end
        return r;
    endfunction

    // Saturating increment/decrement of one counter.
    function automatic logic [CTR_WIDTH-1:0] sat_next(input logic [CTR_WIDTH-1:0] cur,
                                                      input logic up);
        logic [CTR_WIDTH-1:0] r;
        r = cur;
        if (up) begin
            if (cur != CTR_MAX) r = cur + CTR_WIDTH'(1);
        end else begin
            if (cur != '0) r = cur - CTR_WIDTH'(1);
        end
        return r;
    endfunction

    // FSM
    state_t                 r_state;
    state_t                 w_state_next;
    logic [INDEX_WIDTH-1:0] r_clr_ptr;
    logic [INDEX_WIDTH-1:0] w_clr_ptr_next;
    logic                   w_in_init;
    logic                   w_in_run;

    // Pattern history table and its read registers
    logic [CTR_WIDTH-1:0]   r_pht [DEPTH];
    logic [CTR_WIDTH-1:0]   r_rd_a;
    logic [CTR_WIDTH-1:0]   r_rd_b;

    // Prediction path
    logic [HIST_LEN-1:0]    r_ghr;
    logic [HIST_LEN-1:0]    w_ghr_next;
    logic [HIST_LEN-1:0]    w_ghr_eff;
    logic [INDEX_WIDTH-1:0] w_pc_idx;
    logic [INDEX_WIDTH-1:0] w_hist_idx;
    logic [INDEX_WIDTH-1:0] w_pred_idx;
    logic                   w_pred_accept;
    logic                   r_resp_valid;
    logic [INDEX_WIDTH-1:0] r_resp_index;
    logic [HIST_LEN-1:0]    r_resp_ghr;
    logic                   w_resp_taken;

    // Update pipeline
    logic                   w_upd_accept;
    logic                   r_u1_valid;
    logic [INDEX_WIDTH-1:0] r_u1_index;
    logic                   r_u1_taken;
    logic                   r_u2_valid;
    logic [INDEX_WIDTH-1:0] r_u2_index;
    logic [CTR_WIDTH-1:0]   r_u2_data;
    logic [CTR_WIDTH-1:0]   w_u1_cur;
    logic [CTR_WIDTH-1:0]   w_u1_new;

    // Port B write mux (table clear or update write-back)
    logic                   w_b_we;
    logic [INDEX_WIDTH-1:0] w_b_waddr;
    logic [CTR_WIDTH-1:0]   w_b_wdata;

    logic                   w_unused_pc;

    // State register: reset always restarts the table clear from entry 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // Next state: sweep every entry once in INIT, then stay in RUN.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_in_init      = 1'b0;
        w_in_run       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_in_init      = 1'b1;
                w_clr_ptr_next = r_clr_ptr + INDEX_WIDTH'(1);
                if (r_clr_ptr == '1) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_run = 1'b1;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    assign w_pred_accept = bp.pred_valid & w_in_run;
    assign w_upd_accept  = bp.upd_valid & w_in_run;
    assign w_resp_taken  = r_rd_a[CTR_WIDTH-1];
    assign w_pc_idx      = bp.pred_pc[INDEX_WIDTH+1:2];
    assign w_unused_pc   = ^{bp.pred_pc[31:INDEX_WIDTH+2], bp.pred_pc[1:0]};

    // Effective history includes the prediction currently being delivered.
    always_comb begin
        w_ghr_eff = r_resp_valid ? hist_shift(r_ghr, w_resp_taken) : r_ghr;
    end

    // History is left-aligned in the index; low bits stay zero when shorter.
    always_comb begin
        w_hist_idx = '0;
        for (int i = 0; i < HIST_LEN; i++) begin
            w_hist_idx[INDEX_WIDTH-HIST_LEN+i] = w_ghr_eff[i];
        end
        w_pred_idx = (MODE != 0) ? (w_pc_idx ^ w_hist_idx) : w_pc_idx;
    end

    // Speculative shift each delivered prediction; a mispredict restore wins.
    always_comb begin
        w_ghr_next = r_ghr;
        if (w_upd_accept && bp.upd_mispredict) begin
            w_ghr_next = hist_shift(bp.upd_ghr, bp.upd_taken);
        end else if (r_resp_valid) begin
            w_ghr_next = hist_shift(r_ghr, w_resp_taken);
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    // Port A: prediction read, read-first against a same-cycle port B write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_a <= '0;
        end else if (w_pred_accept) begin
            r_rd_a <= r_pht[w_pred_idx];
        end
    end

    // Response registers carried down the pipe for the later update.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_resp_valid <= 1'b0;
            r_resp_index <= '0;
            r_resp_ghr   <= '0;
        end else begin
            r_resp_valid <= w_pred_accept;
            if (w_pred_accept) begin
                r_resp_index <= w_pred_idx;
                r_resp_ghr   <= w_ghr_eff;
            end
        end
    end

    // Port B read: first stage of the update read-modify-write.
    always_ff @(posedge clk) begin
        if (w_upd_accept) begin
            r_rd_b <= r_pht[bp.upd_index];
        end
    end

    // U1 stage control; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_u1_valid <= 1'b0;
            r_u1_index <= '0;
            r_u1_taken <= 1'b0;
        end else begin
            r_u1_valid <= w_upd_accept;
            if (w_upd_accept) begin
                r_u1_index <= bp.upd_index;
                r_u1_taken <= bp.upd_taken;
            end
        end
    end

    // The RAM read in U1 raced the previous write to the same entry, so take
    // the value just written instead.
    always_comb begin
        w_u1_cur = r_rd_b;
        if (r_u2_valid && (r_u2_index == r_u1_index)) begin
            w_u1_cur = r_u2_data;
        end
        w_u1_new = sat_next(w_u1_cur, r_u1_taken);
    end

    // U2 stage holds the entry written by the update leaving U1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_u2_valid <= 1'b0;
            r_u2_index <= '0;
            r_u2_data  <= '0;
        end else begin
            r_u2_valid <= r_u1_valid;
            if (r_u1_valid) begin
                r_u2_index <= r_u1_index;
                r_u2_data  <= w_u1_new;
            end
        end
    end

    // Port B write source: table clear owns the port during INIT.
    always_comb begin
        w_b_we    = 1'b0;
        w_b_waddr = r_u1_index;
        w_b_wdata = w_u1_new;
        if (w_in_init) begin
            w_b_we    = rstn;
            w_b_waddr = r_clr_ptr;
            w_b_wdata = CTR_WEAK_NT;
        end else if (r_u1_valid) begin
            w_b_we = rstn;
        end
    end

    // PHT write port.
    always_ff @(posedge clk) begin
        if (w_b_we) begin
            r_pht[w_b_waddr] <= w_b_wdata;
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    // Resolved-branch and mispredict counters, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_upd_accept) begin
            r_stat_updates <= r_stat_updates + 32'd1;
            if (bp.upd_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    assign bp.pred_ready = w_in_run;
    assign bp.resp_valid = r_resp_valid;
    assign bp.resp_taken = w_resp_taken;
    assign bp.resp_index = r_resp_index;
    assign bp.resp_ghr   = r_resp_ghr;
    assign bp.dbg_state  = r_state;

endmodule

// File: tb/tb_gshare_predictor_x.sv
// Directed bench for gshare_predictor_x. Three instances share clock/reset:
//   0: INDEX 10, HIST 10, CTR 2, bimodal
//   1: INDEX 10, HIST 10, CTR 2, gshare
//   2: INDEX 4,  HIST 4,  CTR 3, bimodal
// Inputs are driven and outputs sampled on the falling edge.
module tb_gshare_predictor_x;

    logic clk;
    logic rstn;

    logic [2:0]       pred_valid;
    logic [2:0][31:0] pred_pc;
    logic [2:0]       upd_valid;
    logic [2:0][9:0]  upd_index;
    logic [2:0]       upd_taken;
    logic [2:0]       upd_mis;
    logic [2:0][9:0]  upd_ghr;

    wire  [2:0]       o_ready;
    wire  [2:0]       o_rvalid;
    wire  [2:0]       o_taken;
    wire  [2:0][9:0]  o_index;
    wire  [2:0][9:0]  o_ghr;
    wire  [2:0]       o_state;
`ifdef PRED_STATS_EN
    wire  [2:0][31:0] stat_upd;
    wire  [2:0][31:0] stat_mis;
`endif

    int n_checks;
    int n_pass;
    int ready_low [3];

    logic       r_v;
    logic       r_t;
    logic [9:0] r_idx;
    logic [9:0] r_gh;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int IW = (g == 2) ? 4 : 10;
        localparam int CW = (g == 2) ? 3 : 2;
        localparam int MD = (g == 1) ? 1 : 0;

        gshare_predictor_x_if #(.INDEX_WIDTH(IW), .HIST_LEN(IW)) bif ();

        assign bif.pred_valid     = pred_valid[g];
        assign bif.pred_pc        = pred_pc[g];
        assign bif.upd_valid      = upd_valid[g];
        assign bif.upd_index      = upd_index[g][IW-1:0];
        assign bif.upd_taken      = upd_taken[g];
        assign bif.upd_mispredict = upd_mis[g];
        assign bif.upd_ghr        = upd_ghr[g][IW-1:0];
        assign o_ready[g]         = bif.pred_ready;
        assign o_rvalid[g]        = bif.resp_valid;
        assign o_taken[g]         = bif.resp_taken;
        assign o_index[g]         = 10'(bif.resp_index);
        assign o_ghr[g]           = 10'(bif.resp_ghr);
        assign o_state[g]         = bif.dbg_state;

        gshare_predictor_x #(
            .INDEX_WIDTH(IW),
            .HIST_LEN   (IW),
            .CTR_WIDTH  (CW),
            .MODE       (MD)
        ) u_dut (
            .clk (clk),
            .rstn(rstn),
            .bp  (bif)
`ifdef PRED_STATS_EN
            ,
            .stat_updates    (stat_upd[g]),
            .stat_mispredicts(stat_mis[g])
`endif
        );
    end

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle prediction request; returns the response seen a cycle later.
    task automatic predict(input int d, input logic [31:0] pc,
                           output logic v, output logic t,
                           output logic [9:0] idx, output logic [9:0] gh);
        pred_valid[d] = 1'b1;
        pred_pc[d]    = pc;
        @(negedge clk);
        pred_valid[d] = 1'b0;
        v   = o_rvalid[d];
        t   = o_taken[d];
        idx = o_index[d];
        gh  = o_ghr[d];
    endtask

    // One-cycle update strobe; back-to-back calls give consecutive updates.
    task automatic update(input int d, input logic [9:0] idx, input logic tk,
                          input logic mis, input logic [9:0] gh);
        upd_valid[d] = 1'b1;
        upd_index[d] = idx;
        upd_taken[d] = tk;
        upd_mis[d]   = mis;
        upd_ghr[d]   = gh;
        @(negedge clk);
        upd_valid[d] = 1'b0;
        upd_mis[d]   = 1'b0;
    endtask

    // Release reset and count the cycles each instance keeps pred_ready low.
    task automatic release_and_count();
        rstn = 1'b1;
        for (int d = 0; d < 3; d++) ready_low[d] = 0;
        for (int n = 0; n < 1200; n++) begin
            for (int d = 0; d < 3; d++) begin
                if (!o_ready[d]) ready_low[d]++;
            end
            if (&o_ready) break;
            @(negedge clk);
        end
        check("ready_after_init", 32'(o_ready), 32'h7);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rstn       = 1'b0;
        pred_valid = '0;
        pred_pc    = '0;
        upd_valid  = '0;
        upd_index  = '0;
        upd_taken  = '0;
        upd_mis    = '0;
        upd_ghr    = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready",      32'(o_ready),    32'h0);
        check("rst_resp_valid", 32'(o_rvalid),   32'h0);
        check("rst_resp_taken", 32'(o_taken),    32'h0);
        check("rst_resp_index", 32'(o_index[1]), 32'h0);
        check("rst_resp_ghr",   32'(o_ghr[1]),   32'h0);
        check("rst_state",      32'(o_state),    32'h0);

        // Table clear length
        release_and_count();
        check("init_len_iw4",  32'(ready_low[2]), 32'd16);
        check("init_len_iw10", 32'(ready_low[0]), 32'd1024);

        // First prediction after clear: weak-not-taken, empty history
        predict(2, 32'h0000_1234, r_v, r_t, r_idx, r_gh);
        check("first_valid", 32'(r_v),   32'h1);
        check("first_taken", 32'(r_t),   32'h0);
        check("first_ghr",   32'(r_gh),  32'h0);
        check("first_index", 32'(r_idx), 32'hD);

        // Bimodal, repeated taken updates on entry 0x10 (1 -> 2 -> 3 -> 3)
        predict(0, 32'h40, r_v, r_t, r_idx, r_gh);
        check("bim_pre_taken", 32'(r_t),   32'h0);
        check("bim_index",     32'(r_idx), 32'h10);
        update(0, 10'h10, 1'b1, 1'b0, 10'h0);
        update(0, 10'h10, 1'b1, 1'b0, 10'h0);
        update(0, 10'h10, 1'b1, 1'b0, 10'h0);
        idle(2);
        predict(0, 32'h40, r_v, r_t, r_idx, r_gh);
        check("bim_sat_taken", 32'(r_t), 32'h1);
        // Two consecutive not-taken: 3 -> 2 -> 1 needs forwarding
        update(0, 10'h10, 1'b0, 1'b0, 10'h0);
        update(0, 10'h10, 1'b0, 1'b0, 10'h0);
        idle(2);
        predict(0, 32'h40, r_v, r_t, r_idx, r_gh);
        check("bim_fwd_dec", 32'(r_t), 32'h0);
        update(0, 10'h10, 1'b1, 1'b0, 10'h0);
        idle(2);
        predict(0, 32'h40, r_v, r_t, r_idx, r_gh);
        check("bim_inc_again", 32'(r_t), 32'h1);

        // Gshare: preset entry 0 to 3, then back-to-back requests at 0x0, 0x4
        update(1, 10'h0, 1'b1, 1'b0, 10'h0);
        update(1, 10'h0, 1'b1, 1'b0, 10'h0);
        idle(2);
        pred_valid[1] = 1'b1;
        pred_pc[1]    = 32'h0;
        @(negedge clk);
        pred_pc[1]    = 32'h4;
        check("b2b_first_taken", 32'(o_taken[1]), 32'h1);
        check("b2b_first_index", 32'(o_index[1]), 32'h0);
        check("b2b_first_ghr",   32'(o_ghr[1]),   32'h0);
        @(negedge clk);
        pred_valid[1] = 1'b0;
        check("b2b_second_valid", 32'(o_rvalid[1]), 32'h1);
        check("b2b_second_ghr",   32'(o_ghr[1]),    32'h1);
        check("b2b_second_index", 32'(o_index[1]),  32'h0);
        check("b2b_second_taken", 32'(o_taken[1]),  32'h1);

        // History is now 0b11; pc 0xC maps back to entry 0 (taken)
        pred_valid[1] = 1'b1;
        pred_pc[1]    = 32'hC;
        @(negedge clk);
        pred_valid[1] = 1'b0;
        check("spec_taken", 32'(o_taken[1]), 32'h1);
        check("spec_ghr",   32'(o_ghr[1]),   32'h3);
        check("spec_index", 32'(o_index[1]), 32'h0);
        // Mispredict restore in the same cycle as that taken response
        update(1, 10'h200, 1'b0, 1'b1, 10'h005);
        predict(1, 32'h0, r_v, r_t, r_idx, r_gh);
        check("restore_ghr",   32'(r_gh),  32'h00A);
        check("restore_index", 32'(r_idx), 32'h00A);
        check("restore_taken", 32'(r_t),   32'h0);
        predict(1, 32'h0, r_v, r_t, r_idx, r_gh);
        check("shift_nt_ghr",   32'(r_gh),  32'h014);
        check("shift_nt_index", 32'(r_idx), 32'h014);

        // 3-bit counters on entry 5 (starts at 3)
        for (int i = 0; i < 8; i++) update(2, 10'h5, 1'b0, 1'b0, 10'h0);
        idle(2);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("c3_floor_taken", 32'(r_t),   32'h0);
        check("c3_index",       32'(r_idx), 32'h5);
        for (int i = 0; i < 3; i++) update(2, 10'h5, 1'b1, 1'b0, 10'h0);
        idle(2);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("c3_at_3", 32'(r_t), 32'h0);
        for (int i = 0; i < 4; i++) update(2, 10'h5, 1'b1, 1'b0, 10'h0);
        idle(2);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("c3_at_7", 32'(r_t), 32'h1);
        update(2, 10'h5, 1'b1, 1'b0, 10'h0);
        for (int i = 0; i < 3; i++) update(2, 10'h5, 1'b0, 1'b0, 10'h0);
        idle(2);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("c3_ceiling_then_4", 32'(r_t), 32'h1);
        // Predict read racing the write of 4 -> 3: old value returned
        update(2, 10'h5, 1'b0, 1'b0, 10'h0);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("read_first_old", 32'(r_t), 32'h1);
        predict(2, 32'h14, r_v, r_t, r_idx, r_gh);
        check("read_first_new", 32'(r_t), 32'h0);

`ifdef PRED_STATS_EN
        // Statistics from a fresh reset: 5 updates, 2 mispredicts
        rstn = 1'b0;
        idle(2);
        release_and_count();
        update(0, 10'h3, 1'b1, 1'b1, 10'h0);
        update(0, 10'h3, 1'b1, 1'b0, 10'h0);
        update(0, 10'h3, 1'b0, 1'b1, 10'h0);
        update(0, 10'h3, 1'b1, 1'b0, 10'h0);
        update(0, 10'h3, 1'b0, 1'b0, 10'h0);
        idle(1);
        check("stat_updates",     stat_upd[0], 32'd5);
        check("stat_mispredicts", stat_mis[0], 32'd2);
`endif

        // Reset, then a second reset in the middle of the clear
        rstn = 1'b0;
        idle(2);
`ifdef PRED_STATS_EN
        check("stat_updates_rst",     stat_upd[0], 32'd0);
        check("stat_mispredicts_rst", stat_mis[0], 32'd0);
`endif
        rstn = 1'b1;
        idle(5);
        check("mid_init_not_ready", 32'(o_ready[2]), 32'h0);
        rstn = 1'b0;
        idle(2);
        release_and_count();
        check("init_restart_len", 32'(ready_low[2]), 32'd16);
        predict(0, 32'h40, r_v, r_t, r_idx, r_gh);
        check("cleared_entry_taken", 32'(r_t), 32'h0);
        predict(1, 32'h0, r_v, r_t, r_idx, r_gh);
        check("cleared_ghr", 32'(r_gh), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
